// File: rtl/pico_pkg.sv
// Shared widths, instruction field positions and enumerations for the picoMIPS sequencer.
// Every other sequencer file imports this package.
package pico_pkg;

    localparam int DATA_BUS_SIZE  = 8;
    localparam int REGISTERS_SIZE = 3;
    localparam int INSTR_SIZE     = 3 + 2 * REGISTERS_SIZE + DATA_BUS_SIZE;

    localparam int OPC_MSB = 16;
    localparam int OPC_LSB = 14;
    localparam int RD_MSB  = 13;
    localparam int RD_LSB  = 11;
    localparam int RS_MSB  = 10;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Register that holds the inport value; WAITIN reads it through the ALU pass path.
    localparam logic [REGISTERS_SIZE-1:0] INPORT_REG = 3'b001;

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_ADD    = 3'b001,
        OP_ADDI   = 3'b010,
        OP_MULI   = 3'b011,
        OP_BEQ    = 3'b100,
        OP_JMP    = 3'b101,
        OP_WAITIN = 3'b110,
        OP_HALT   = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_WAIT_PRESS,
        ST_WAIT_RELEASE,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10,
        ALU_MULH = 2'b11
    } alu_op_t;

    // Registers 0 and 1 are read-only; writes to them are silently dropped.
    function automatic logic rd_writable(input logic [REGISTERS_SIZE-1:0] rd);
        return rd[REGISTERS_SIZE-1:1] != '0;
    endfunction

endpackage

// File: rtl/pico_sequencer_if.sv
// Control bundle between the sequencer and the PC / register file / ALU datapath.
// master = sequencer side, slave = datapath side.
interface pico_sequencer_if;
    import pico_pkg::*;

    logic [INSTR_SIZE-1:0]     instr;
    logic                      alu_zero;
    logic                      in_valid;
    logic                      pc_inc;
    logic                      pc_load;
    logic                      reg_w;
    logic [REGISTERS_SIZE-1:0] r_dest;
    logic [REGISTERS_SIZE-1:0] r_source;
    logic [DATA_BUS_SIZE-1:0]  imm;
    alu_op_t                   alu_op;
    logic                      alu_imm_sel;
    logic                      in_ack;
    logic                      halted;

    modport master (
        input  instr, alu_zero, in_valid,
        output pc_inc, pc_load, reg_w, r_dest, r_source, imm,
               alu_op, alu_imm_sel, in_ack, halted
    );

    modport slave (
        output instr, alu_zero, in_valid,
        input  pc_inc, pc_load, reg_w, r_dest, r_source, imm,
               alu_op, alu_imm_sel, in_ack, halted
    );
endinterface

// File: rtl/pico_decode.sv
// Purely combinational instruction decode: IR opcode to ALU controls and
// instruction-class flags consumed by the sequencer FSM.
module pico_decode
    import pico_pkg::*;
(
    input  logic [INSTR_SIZE-1:0] ir,
    output alu_op_t               alu_op,
    output logic                  alu_imm_sel,
    output logic                  writes_rd,
    output logic                  is_branch,
    output logic                  is_jump,
    output logic                  is_wait,
    output logic                  is_halt
);

    opcode_t opcode;
    assign opcode = opcode_t'(ir[OPC_MSB:OPC_LSB]);

    always_comb begin
        alu_op      = ALU_PASS;
        alu_imm_sel = 1'b0;
        writes_rd   = 1'b0;
        is_branch   = 1'b0;
        is_jump     = 1'b0;
        is_wait     = 1'b0;
        is_halt     = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_op    = ALU_ADD;
                writes_rd = 1'b1;
            end
            OP_ADDI: begin
                alu_op      = ALU_ADD;
                alu_imm_sel = 1'b1;
                writes_rd   = 1'b1;
            end
            OP_MULI: begin
                alu_op      = ALU_MULH;
                alu_imm_sel = 1'b1;
                writes_rd   = 1'b1;
            end
            // Equality test is a subtraction of rs from rd; the ALU zero flag decides.
            OP_BEQ: begin
                alu_op    = ALU_SUB;
                is_branch = 1'b1;
            end
            OP_JMP:    is_jump = 1'b1;
            OP_WAITIN: begin
                writes_rd = 1'b1;
                is_wait   = 1'b1;
            end
            OP_HALT:   is_halt = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: rtl/pico_sequencer.sv
// Multicycle picoMIPS control FSM: FETCH/DECODE/EXEC/WB plus an inport
// press/release handshake and an absorbing HALT state.
module pico_sequencer
    import pico_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    pico_sequencer_if.master bus
);

    logic [INSTR_SIZE-1:0] ir_reg;
    state_t                state_reg, state_next;
    logic                  taken_reg, taken_next;

    alu_op_t dec_alu_op;
    logic    dec_imm_sel;
    logic    dec_writes_rd;
    logic    dec_is_branch;
    logic    dec_is_jump;
    logic    dec_is_wait;
    logic    dec_is_halt;

    logic pc_inc_next;
    logic pc_load_next;
    logic reg_w_next;
    logic in_ack_next;

    pico_decode u_decode (
        .ir          (ir_reg),
        .alu_op      (dec_alu_op),
        .alu_imm_sel (dec_imm_sel),
        .writes_rd   (dec_writes_rd),
        .is_branch   (dec_is_branch),
        .is_jump     (dec_is_jump),
        .is_wait     (dec_is_wait),
        .is_halt     (dec_is_halt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_FETCH;
            ir_reg    <= '0;
            taken_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            taken_reg <= taken_next;
            if (state_reg == ST_FETCH) begin
                ir_reg <= bus.instr;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        taken_next   = taken_reg;
        pc_inc_next  = 1'b0;
        pc_load_next = 1'b0;
        reg_w_next   = 1'b0;
        in_ack_next  = 1'b0;
        case (state_reg)
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: begin
                taken_next = 1'b0;
                if (dec_is_halt) begin
                    state_next = ST_HALT;
                end else if (dec_is_wait) begin
                    state_next = ST_WAIT_PRESS;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            // alu_zero is only meaningful here, so the branch decision is captured for WB.
            ST_EXEC: begin
                taken_next = dec_is_branch & bus.alu_zero;
                state_next = ST_WB;
            end
            ST_WB: begin
                reg_w_next = dec_writes_rd & rd_writable(ir_reg[RD_MSB:RD_LSB]);
                if (dec_is_jump || taken_reg) begin
                    pc_load_next = 1'b1;
                end else begin
                    pc_inc_next = 1'b1;
                end
                state_next = ST_FETCH;
            end
            ST_WAIT_PRESS: begin
                if (bus.in_valid) begin
                    in_ack_next = 1'b1;
                    state_next  = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!bus.in_valid) begin
                    state_next = ST_WB;
                end
            end
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_FETCH;
        endcase
    end

    // A reset in the same cycle cancels any write, PC update or acknowledge.
    assign bus.pc_inc      = pc_inc_next & ~reset;
    assign bus.pc_load     = pc_load_next & ~reset;
    assign bus.reg_w       = reg_w_next & ~reset;
    assign bus.in_ack      = in_ack_next & ~reset;
    assign bus.halted      = (state_reg == ST_HALT) & ~reset;

    assign bus.r_dest      = ir_reg[RD_MSB:RD_LSB];
    assign bus.r_source    = dec_is_wait ? INPORT_REG : ir_reg[RS_MSB:RS_LSB];
    assign bus.imm         = ir_reg[IMM_MSB:IMM_LSB];
    assign bus.alu_op      = dec_alu_op;
    assign bus.alu_imm_sel = dec_imm_sel;

endmodule

// File: tb/tb_pico_sequencer.sv
// Directed bench for pico_sequencer: a table of single-instruction runs plus
// hand-written sequences for reset, WAITIN handshake and HALT corner cases.
module tb_pico_sequencer;
    import pico_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pico_sequencer_if bus ();

    pico_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] instr;
        logic        zero;
        logic        w;
        logic        inc;
        logic        ld;
        logic [2:0]  rd;
        logic [1:0]  op;
        logic        sel;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [16:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pulses();
        return {bus.reg_w, bus.pc_inc, bus.pc_load, bus.in_ack};
    endfunction

    // Leaves the DUT in its first FETCH cycle with reset released.
    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.alu_zero = 1'b0;
        bus.instr    = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        do_reset();
        bus.instr = v.instr;
        tick();
        chk($sformatf("v%0d decode pulses", i), 32'(pulses()), 32'h0);
        chk($sformatf("v%0d r_dest", i), 32'(bus.r_dest), 32'(v.rd));
        chk($sformatf("v%0d alu_op", i), 32'(bus.alu_op), 32'(v.op));
        chk($sformatf("v%0d alu_imm_sel", i), 32'(bus.alu_imm_sel), 32'(v.sel));
        chk($sformatf("v%0d imm", i), 32'(bus.imm), 32'(v.instr[7:0]));
        tick();
        bus.alu_zero = v.zero;
        #1;
        chk($sformatf("v%0d exec pulses", i), 32'(pulses()), 32'h0);
        tick();
        bus.alu_zero = ~v.zero;
        #1;
        chk($sformatf("v%0d wb reg_w/pc_inc/pc_load", i),
            32'({bus.reg_w, bus.pc_inc, bus.pc_load}), 32'({v.w, v.inc, v.ld}));
        bus.instr = mk(3'b000, 3'd0, 3'd0, 8'h00);
        tick();
        chk($sformatf("v%0d fetch pulses", i), 32'(pulses()), 32'h0);
        $display("vec %0d instr=%05h zero=%0d reg_w=%0d pc_inc=%0d pc_load=%0d",
                 i, v.instr, v.zero, v.w, v.inc, v.ld);
    endtask

    initial begin : main
        int acks;
        int stray;
        checks = 0;
        errors = 0;

        //          instr                          zero w  inc ld  rd    op     sel
        vecs[0]  = '{mk(3'b010, 3'd3, 3'd0, 8'h05), 0, 1, 1, 0, 3'd3, 2'b01, 1};
        vecs[1]  = '{mk(3'b001, 3'd4, 3'd2, 8'h00), 0, 1, 1, 0, 3'd4, 2'b01, 0};
        vecs[2]  = '{mk(3'b011, 3'd6, 3'd0, 8'h10), 0, 1, 1, 0, 3'd6, 2'b11, 1};
        vecs[3]  = '{mk(3'b100, 3'd3, 3'd4, 8'hFE), 1, 0, 0, 1, 3'd3, 2'b10, 0};
        vecs[4]  = '{mk(3'b100, 3'd3, 3'd4, 8'hFE), 0, 0, 1, 0, 3'd3, 2'b10, 0};
        vecs[5]  = '{mk(3'b101, 3'd0, 3'd0, 8'h03), 0, 0, 0, 1, 3'd0, 2'b00, 0};
        vecs[6]  = '{mk(3'b101, 3'd0, 3'd0, 8'h80), 1, 0, 0, 1, 3'd0, 2'b00, 0};
        vecs[7]  = '{mk(3'b000, 3'd5, 3'd6, 8'h11), 1, 0, 1, 0, 3'd5, 2'b00, 0};
        vecs[8]  = '{mk(3'b001, 3'd0, 3'd3, 8'h00), 0, 0, 1, 0, 3'd0, 2'b01, 0};
        vecs[9]  = '{mk(3'b010, 3'd1, 3'd0, 8'h07), 0, 0, 1, 0, 3'd1, 2'b01, 1};
        vecs[10] = '{mk(3'b010, 3'd2, 3'd0, 8'h09), 0, 1, 1, 0, 3'd2, 2'b01, 1};
        vecs[11] = '{mk(3'b001, 3'd7, 3'd5, 8'h00), 1, 1, 1, 0, 3'd7, 2'b01, 0};

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while in DECODE, then a full ADDI run.
        do_reset();
        bus.instr = mk(3'b010, 3'd3, 3'd0, 8'h05);
        tick();
        reset = 1'b1;
        #1;
        chk("rst_decode pulses during reset", 32'(pulses()), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_decode pulses", 32'(pulses()), 32'h0);
        chk("rst_decode halted", 32'(bus.halted), 32'h0);
        chk("rst_decode fields", 32'({bus.r_dest, bus.r_source, bus.imm, bus.alu_op, bus.alu_imm_sel}), 32'h0);
        tick();
        chk("rst_decode c2 reg_w", 32'(bus.reg_w), 32'h0);
        tick();
        chk("rst_decode c3 reg_w", 32'(bus.reg_w), 32'h0);
        tick();
        chk("rst_decode c4 reg_w/pc_inc/pc_load", 32'({bus.reg_w, bus.pc_inc, bus.pc_load}), 32'b110);
        chk("rst_decode c4 r_dest/imm/sel", 32'({bus.r_dest, bus.imm, bus.alu_imm_sel}), 32'({3'd3, 8'h05, 1'b1}));
        $display("seq reset_in_decode then ADDI rd=3 imm=05");

        // WAITIN rd=5: 10 idle cycles, 3 held cycles, release.
        do_reset();
        bus.instr = mk(3'b110, 3'd5, 3'd0, 8'h00);
        tick();
        tick();
        acks  = 0;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            acks  += int'(bus.in_ack);
            stray += int'(bus.reg_w | bus.pc_inc | bus.pc_load);
            tick();
        end
        chk("waitin ack while idle", 32'(acks), 32'd0);
        bus.in_valid = 1'b1;
        #1;
        chk("waitin ack on press", 32'(bus.in_ack), 32'h1);
        for (int c = 0; c < 3; c++) begin
            acks  += int'(bus.in_ack);
            stray += int'(bus.reg_w | bus.pc_inc | bus.pc_load);
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        stray += int'(bus.reg_w | bus.pc_inc | bus.pc_load);
        acks  += int'(bus.in_ack);
        chk("waitin ack count", 32'(acks), 32'd1);
        chk("waitin stray pulses in wait", 32'(stray), 32'd0);
        tick();
        chk("waitin wb reg_w/pc_inc/pc_load", 32'({bus.reg_w, bus.pc_inc, bus.pc_load}), 32'b110);
        chk("waitin wb r_dest/r_source/alu_op", 32'({bus.r_dest, bus.r_source, bus.alu_op}), 32'({3'd5, 3'd1, 2'b00}));
        tick();
        chk("waitin fetch pulses", 32'(pulses()), 32'h0);
        $display("seq WAITIN rd=5 acks=%0d", acks);

        // WAITIN rd=1 with the button already held at decode: immediate ack, no write.
        do_reset();
        bus.instr    = mk(3'b110, 3'd1, 3'd0, 8'h00);
        bus.in_valid = 1'b1;
        tick();
        tick();
        chk("waitin_ro first press ack", 32'(bus.in_ack), 32'h1);
        tick();
        chk("waitin_ro held no ack", 32'(bus.in_ack), 32'h0);
        bus.in_valid = 1'b0;
        tick();
        chk("waitin_ro wb reg_w/pc_inc", 32'({bus.reg_w, bus.pc_inc}), 32'b01);
        $display("seq WAITIN rd=1 pre-held button");

        // HALT absorbs for 20 cycles until reset.
        do_reset();
        bus.instr = mk(3'b111, 3'd0, 3'd0, 8'h00);
        tick();
        chk("halt decode halted", 32'(bus.halted), 32'h0);
        tick();
        stray = 0;
        acks  = 0;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = c[0];
            #1;
            stray += int'(pulses() != 4'h0);
            acks  += int'(!bus.halted);
            tick();
        end
        chk("halt pulses in 20 cycles", 32'(stray), 32'd0);
        chk("halt low cycles in 20", 32'(acks), 32'd0);
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr    = mk(3'b000, 3'd0, 3'd0, 8'h00);
        #1;
        chk("halt after reset halted", 32'(bus.halted), 32'h0);
        tick();
        tick();
        tick();
        chk("halt after reset nop wb pc_inc", 32'({bus.pc_inc, bus.pc_load}), 32'b10);
        $display("seq HALT then reset");

        // Reset in WAIT_RELEASE cancels the pending write.
        do_reset();
        bus.instr    = mk(3'b110, 3'd5, 3'd0, 8'h00);
        bus.in_valid = 1'b1;
        tick();
        tick();
        tick();
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        #1;
        chk("rst_release pulses during reset", 32'(pulses()), 32'h0);
        tick();
        reset = 1'b0;
        bus.instr = mk(3'b000, 3'd0, 3'd0, 8'h00);
        #1;
        chk("rst_release pulses after", 32'(pulses()), 32'h0);
        tick();
        tick();
        tick();
        chk("rst_release nop wb pc_inc", 32'({bus.reg_w, bus.pc_inc}), 32'b01);
        $display("seq reset in WAIT_RELEASE");

        // Reset asserted in WB cancels write and PC increment.
        do_reset();
        bus.instr = mk(3'b010, 3'd4, 3'd0, 8'h01);
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rst_wb pulses", 32'(pulses()), 32'h0);
        tick();
        reset = 1'b0;
        $display("seq reset in WB");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
